// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: shares one Wishbone B3 classic master port between the
// instruction-fetch (IF) and data-access (MEM) requesters of the MIPS32 core.
// MEM has fixed priority. Returned data is held in registers until the
// requesting stage advances. Flushes, slave errors and hung slaves are
// handled without leaving the bus open.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall_i[5:0], flush_i    pipeline stall vector (bit1 IF, bit4 MEM), flush
//   if_ce_i, if_addr_i       fetch request and address
//   if_data_o                fetched instruction (registered)
//   stall_req_if             IF stall request (combinational)
//   mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i
//                            data request, write enable, byte enables, address, store data
//   mem_data_o               load data (registered)
//   stall_req_mem            MEM stall request (combinational)
//   wb_cyc_o .. wb_dat_o     registered Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i  Wishbone slave response
//   bus_err_o                one-cycle pulse on slave error or timeout
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        stall_req_if,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stall_req_mem,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err_o
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 4;
  localparam int unsigned CW  = 8;
  localparam logic        OWN_IF  = 1'b0;
  localparam logic        OWN_MEM = 1'b1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            if_done_q, if_done_d;
  logic            mem_done_q, mem_done_d;
  logic            discard_q, discard_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW-1:0]   if_data_q, if_data_d;
  logic [DW-1:0]   mem_data_q, mem_data_d;
  logic            bus_err_q, bus_err_d;

  logic if_pend_c, mem_pend_c, start_c, timeout_c, term_c, fail_c, drop_c;

  // Only the IF and MEM stall bits matter here.
  logic unused_stall_c;
  assign unused_stall_c = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  assign if_pend_c  = if_ce_i & ~if_done_q;
  assign mem_pend_c = mem_ce_i & ~mem_done_q;
  assign start_c    = (state_q == S_IDLE) & ~flush_i & (if_pend_c | mem_pend_c);
  assign timeout_c  = (cnt_q == CW'(TIMEOUT - 1));
  assign term_c     = (state_q == S_BUSY) & (wb_ack_i | wb_err_i | timeout_c);
  // err wins over a simultaneous ack; no ack at termination means timeout
  assign fail_c     = wb_err_i | ~wb_ack_i;
  // a flush in the terminating clock discards the result just like an earlier one
  assign drop_c     = discard_q | flush_i;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      discard_q  <= 1'b0;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_c) state_d = S_BUSY;
      S_BUSY: if (term_c)  state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  // Bus outputs, counter, done flags and data registers
  always_comb begin
    owner_d    = owner_q;
    if_done_d  = if_done_q;
    mem_done_d = mem_done_q;
    discard_d  = discard_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
    bus_err_d  = 1'b0;

    // done holds while the stage is stalled so data survives foreign stalls
    if (if_done_q && !stall_i[1])  if_done_d  = 1'b0;
    if (mem_done_q && !stall_i[4]) mem_done_d = 1'b0;
    if (flush_i) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
    end

    if (start_c) begin
      owner_d = mem_pend_c ? OWN_MEM : OWN_IF;
      cnt_d   = '0;
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      if (mem_pend_c) begin
        adr_d = mem_addr_i;
        sel_d = mem_sel_i;
        we_d  = mem_we_i;
        dat_d = mem_data_i;
      end else begin
        adr_d = if_addr_i;
        sel_d = '1;
        we_d  = 1'b0;
        dat_d = '0;
      end
    end

    if (state_q == S_BUSY) begin
      cnt_d = cnt_q + CW'(1);
      if (flush_i) discard_d = 1'b1;
    end

    if (term_c) begin
      cnt_d     = '0;
      cyc_d     = 1'b0;
      stb_d     = 1'b0;
      we_d      = 1'b0;
      sel_d     = '0;
      adr_d     = '0;
      dat_d     = '0;
      discard_d = 1'b0;
      bus_err_d = fail_c;
      if (!drop_c) begin
        if (owner_q == OWN_MEM) begin
          mem_done_d = 1'b1;
          if (fail_c)     mem_data_d = '0;
          else if (!we_q) mem_data_d = wb_dat_i;
        end else begin
          if_done_d = 1'b1;
          if_data_d = fail_c ? '0 : wb_dat_i;
        end
      end
    end
  end

  assign stall_req_if  = ~rst & if_ce_i & ~if_done_q;
  assign stall_req_mem = ~rst & mem_ce_i & ~mem_done_q;

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign if_data_o  = if_data_q;
  assign mem_data_o = mem_data_q;
  assign bus_err_o  = bus_err_q;

endmodule
